// File: rtl/fc_debug_pkg.sv
// Shared definitions for the FC debug stream checker: CSR map, ID word,
// framing state type and the packed error-counter word.
package fc_debug_pkg;

    localparam logic [2:0] CSR_PACKETS  = 3'd0;
    localparam logic [2:0] CSR_BEATS    = 3'd1;
    localparam logic [2:0] CSR_BYTES    = 3'd2;
    localparam logic [2:0] CSR_ERRORS   = 3'd3;
    localparam logic [2:0] CSR_LAST_SOP = 3'd4;
    localparam logic [2:0] CSR_MAX_LEN  = 3'd5;
    localparam logic [2:0] CSR_STATUS   = 3'd6;
    localparam logic [2:0] CSR_ID       = 3'd7;

    localparam logic [31:0] CHK_ID = 32'hFC0DC4EC;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } chk_state_t;

    typedef struct packed {
        logic [7:0] chan;
        logic [7:0] empty;
        logic [7:0] sop;
        logic [7:0] orphan;
    } err_word_t;

endpackage

// File: rtl/fc_debug_sat_counter.sv
// Saturating up-counter with a variable increment, synchronous clear and
// asynchronous active-low reset. Sticks at all-ones instead of wrapping.
module fc_debug_sat_counter #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             srst,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    logic [W-1:0] count_r;
    logic [W:0]   sum_s;

    // One extra bit catches the carry out that signals saturation.
    always_comb begin
        sum_s = {1'b0, count_r} + {{(W + 1 - INC_W){1'b0}}, inc};
    end

    // Counter register: clear has priority over counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (srst) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            count_r <= sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fc_debug_checker.sv
// Avalon-ST sink for the FC debug packet stream: framing/empty/channel checks,
// saturating statistics, patterned backpressure and a small Avalon-MM CSR slave.
module fc_debug_checker
    import fc_debug_pkg::*;
#(
    parameter int         DATA_W        = 256,
    parameter int         EMPTY_W       = 5,
    parameter int         CNT_W         = 32,
    parameter logic [7:0] READY_PATTERN = 8'hFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  st_in_data,
    input  logic [1:0]         st_in_channel,
    input  logic               st_in_valid,
    output logic               st_in_ready,
    input  logic               st_in_startofpacket,
    input  logic               st_in_endofpacket,
    input  logic [EMPTY_W-1:0] st_in_empty,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    output logic [31:0]        avs_readdata,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata
);

    localparam logic [EMPTY_W:0] BEAT_BYTES_C = {1'b1, {EMPTY_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};

    logic             ready_r;
    logic [2:0]       idx_r;
    chk_state_t       state_r;
    logic [CNT_W-1:0] len_r;
    logic [1:0]       chan_r;
    logic [CNT_W-1:0] max_len_r;
    logic [31:0]      last_sop_r;
    logic [31:0]      readdata_r;

    logic             beat_s;
    logic             clear_s;
    logic             take_s;
    logic             sop_cap_s;
    chk_state_t       state_nxt_s;
    logic [CNT_W-1:0] len_nxt_s;
    logic             pkt_done_s;
    logic             count_bytes_s;
    logic [EMPTY_W:0] byte_amt_s;
    logic             inc_orphan_s;
    logic             inc_sop_s;
    logic             inc_empty_s;
    logic             inc_chan_s;
    logic [31:0]      rd_mux_s;
    err_word_t        err_word_s;

    logic [CNT_W-1:0] packets_s;
    logic [CNT_W-1:0] beats_s;
    logic [CNT_W-1:0] bytes_s;
    logic [7:0]       err_orphan_s;
    logic [7:0]       err_sop_s;
    logic [7:0]       err_empty_s;
    logic [7:0]       err_chan_s;

    logic             unused_s;

    // Framing decisions for the beat presented this cycle.
    always_comb begin
        beat_s        = st_in_valid && ready_r;
        clear_s       = avs_write && (avs_address == CSR_PACKETS) && avs_writedata[0];
        take_s        = beat_s && !clear_s;
        sop_cap_s     = take_s && st_in_startofpacket;
        byte_amt_s    = st_in_endofpacket ? (BEAT_BYTES_C - {1'b0, st_in_empty}) : BEAT_BYTES_C;
        inc_empty_s   = take_s && !st_in_endofpacket && (st_in_empty != {EMPTY_W{1'b0}});
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        pkt_done_s    = 1'b0;
        count_bytes_s = 1'b0;
        inc_orphan_s  = 1'b0;
        inc_sop_s     = 1'b0;
        inc_chan_s    = 1'b0;
        if (take_s) begin
            case (state_r)
                IDLE: begin
                    if (st_in_startofpacket) begin
                        len_nxt_s     = CNT_ONE_C;
                        count_bytes_s = 1'b1;
                        if (st_in_endofpacket) begin
                            pkt_done_s  = 1'b1;
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = IN_PKT;
                        end
                    end else begin
                        inc_orphan_s = 1'b1;
                    end
                end
                IN_PKT: begin
                    count_bytes_s = 1'b1;
                    // A repeated SOP abandons the open packet and starts afresh.
                    if (st_in_startofpacket) begin
                        inc_sop_s = 1'b1;
                        len_nxt_s = CNT_ONE_C;
                    end else begin
                        inc_chan_s = (st_in_channel != chan_r);
                        len_nxt_s  = (len_r == CNT_MAX_C) ? len_r : (len_r + CNT_ONE_C);
                    end
                    if (st_in_endofpacket) begin
                        pkt_done_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = IN_PKT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Rotating backpressure pattern; free-running after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
            idx_r   <= 3'd0;
        end else begin
            ready_r <= READY_PATTERN[idx_r];
            idx_r   <= idx_r + 3'd1;
        end
    end

    // Framing state, packet length tracking and SOP captures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            len_r      <= {CNT_W{1'b0}};
            chan_r     <= 2'd0;
            max_len_r  <= {CNT_W{1'b0}};
            last_sop_r <= 32'd0;
        end else if (clear_s) begin
            state_r    <= IDLE;
            len_r      <= {CNT_W{1'b0}};
            chan_r     <= 2'd0;
            max_len_r  <= {CNT_W{1'b0}};
            last_sop_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            if (sop_cap_s) begin
                last_sop_r <= st_in_data[DATA_W-1 -: 32];
                chan_r     <= st_in_channel;
            end else begin
                last_sop_r <= last_sop_r;
                chan_r     <= chan_r;
            end
            if (pkt_done_s && (len_nxt_s > max_len_r)) begin
                max_len_r <= len_nxt_s;
            end else begin
                max_len_r <= max_len_r;
            end
        end
    end

    fc_debug_sat_counter #(.W(CNT_W), .INC_W(1)) u_packets (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(pkt_done_s), .inc(1'b1), .count(packets_s)
    );
    fc_debug_sat_counter #(.W(CNT_W), .INC_W(1)) u_beats (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(take_s), .inc(1'b1), .count(beats_s)
    );
    fc_debug_sat_counter #(.W(CNT_W), .INC_W(EMPTY_W + 1)) u_bytes (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(count_bytes_s), .inc(byte_amt_s), .count(bytes_s)
    );
    fc_debug_sat_counter #(.W(8), .INC_W(1)) u_err_orphan (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(inc_orphan_s), .inc(1'b1), .count(err_orphan_s)
    );
    fc_debug_sat_counter #(.W(8), .INC_W(1)) u_err_sop (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(inc_sop_s), .inc(1'b1), .count(err_sop_s)
    );
    fc_debug_sat_counter #(.W(8), .INC_W(1)) u_err_empty (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(inc_empty_s), .inc(1'b1), .count(err_empty_s)
    );
    fc_debug_sat_counter #(.W(8), .INC_W(1)) u_err_chan (
        .clk(clk), .reset_n(reset_n), .srst(clear_s), .en(inc_chan_s), .inc(1'b1), .count(err_chan_s)
    );

    // CSR read multiplexer over the current (pre-clear) statistics.
    always_comb begin
        err_word_s.chan   = err_chan_s;
        err_word_s.empty  = err_empty_s;
        err_word_s.sop    = err_sop_s;
        err_word_s.orphan = err_orphan_s;
        case (avs_address)
            CSR_PACKETS:  rd_mux_s = 32'(packets_s);
            CSR_BEATS:    rd_mux_s = 32'(beats_s);
            CSR_BYTES:    rd_mux_s = 32'(bytes_s);
            CSR_ERRORS:   rd_mux_s = err_word_s;
            CSR_LAST_SOP: rd_mux_s = last_sop_r;
            CSR_MAX_LEN:  rd_mux_s = 32'(max_len_r);
            CSR_STATUS:   rd_mux_s = {30'd0, (state_r == IN_PKT), ready_r};
            CSR_ID:       rd_mux_s = CHK_ID;
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // Read data register: loads on a read strobe, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign st_in_ready  = ready_r;
    assign avs_readdata = readdata_r;
    assign unused_s     = ^{st_in_data[DATA_W-33:0], avs_writedata[31:1]};

endmodule

// File: tb/tb_fc_debug_checker.sv
// Randomised and directed bench for fc_debug_checker: two instances (ready
// patterns FF and A5) checked every cycle against a behavioural statistics model.
module tb_fc_debug_checker;

    logic         clk;
    logic         reset_n;
    logic [255:0] data_v  [2];
    logic [1:0]   ch_v    [2];
    logic         valid_v [2];
    logic         sop_v   [2];
    logic         eop_v   [2];
    logic [4:0]   empty_v [2];
    logic [2:0]   addr_v  [2];
    logic         read_v  [2];
    logic         write_v [2];
    logic [31:0]  wdata_v [2];
    logic         ready_0, ready_1;
    logic [31:0]  rdata_0, rdata_1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state, one slot per DUT instance.
    bit [7:0]    pat     [2];
    bit          m_ready [2];
    int          m_idx   [2];
    bit          m_inpkt [2];
    longint      m_len   [2];
    bit [1:0]    m_chan  [2];
    longint      m_pk    [2];
    longint      m_bt    [2];
    longint      m_by    [2];
    longint      m_max   [2];
    int          m_err   [2][4];   // orphan, sop, empty, chan
    logic [31:0] m_last  [2];
    logic [31:0] m_rd    [2];

    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fc_debug_checker #(.DATA_W(256), .EMPTY_W(5), .CNT_W(32), .READY_PATTERN(8'hFF)) dut_ff (
        .clk(clk), .reset_n(reset_n),
        .st_in_data(data_v[0]), .st_in_channel(ch_v[0]), .st_in_valid(valid_v[0]),
        .st_in_ready(ready_0), .st_in_startofpacket(sop_v[0]), .st_in_endofpacket(eop_v[0]),
        .st_in_empty(empty_v[0]), .avs_address(addr_v[0]), .avs_read(read_v[0]),
        .avs_readdata(rdata_0), .avs_write(write_v[0]), .avs_writedata(wdata_v[0])
    );

    fc_debug_checker #(.DATA_W(256), .EMPTY_W(5), .CNT_W(32), .READY_PATTERN(8'hA5)) dut_a5 (
        .clk(clk), .reset_n(reset_n),
        .st_in_data(data_v[1]), .st_in_channel(ch_v[1]), .st_in_valid(valid_v[1]),
        .st_in_ready(ready_1), .st_in_startofpacket(sop_v[1]), .st_in_endofpacket(eop_v[1]),
        .st_in_empty(empty_v[1]), .avs_address(addr_v[1]), .avs_read(read_v[1]),
        .avs_readdata(rdata_1), .avs_write(write_v[1]), .avs_writedata(wdata_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic clear_stats(input int k);
        m_inpkt[k] = 1'b0;
        m_len[k]   = 0;
        m_chan[k]  = 2'd0;
        m_pk[k]    = 0;
        m_bt[k]    = 0;
        m_by[k]    = 0;
        m_max[k]   = 0;
        m_last[k]  = 32'd0;
        for (int i = 0; i < 4; i++) m_err[k][i] = 0;
    endtask

    task automatic model_reset(input int k);
        clear_stats(k);
        m_ready[k] = 1'b0;
        m_idx[k]   = 0;
        m_rd[k]    = 32'd0;
    endtask

    function automatic logic [31:0] model_csr(input int k, input logic [2:0] a);
        case (a)
            3'd0:    return m_pk[k][31:0];
            3'd1:    return m_bt[k][31:0];
            3'd2:    return m_by[k][31:0];
            3'd3:    return {m_err[k][3][7:0], m_err[k][2][7:0], m_err[k][1][7:0], m_err[k][0][7:0]};
            3'd4:    return m_last[k];
            3'd5:    return m_max[k][31:0];
            3'd6:    return {30'd0, m_inpkt[k], m_ready[k]};
            3'd7:    return 32'hFC0DC4EC;
            default: return 32'd0;
        endcase
    endfunction

    task automatic bump_err(input int k, input int i);
        m_err[k][i] = (m_err[k][i] < 255) ? m_err[k][i] + 1 : 255;
    endtask

    task automatic end_packet(input int k);
        m_pk[k]    = sat(m_pk[k] + 1, CMAX);
        m_max[k]   = (m_len[k] > m_max[k]) ? m_len[k] : m_max[k];
        m_inpkt[k] = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_update(input int k);
        bit     acc, clr;
        longint add;
        if (reset_n !== 1'b1) begin
            model_reset(k);
            return;
        end
        if (read_v[k]) m_rd[k] = model_csr(k, addr_v[k]);
        acc = valid_v[k] && m_ready[k];
        clr = write_v[k] && (addr_v[k] == 3'd0) && wdata_v[k][0];
        m_ready[k] = pat[k][m_idx[k]];
        m_idx[k]   = (m_idx[k] + 1) % 8;
        if (clr) begin
            clear_stats(k);
        end else if (acc) begin
            add = eop_v[k] ? (32 - longint'(empty_v[k])) : 32;
            m_bt[k] = sat(m_bt[k] + 1, CMAX);
            if (!eop_v[k] && empty_v[k] != 5'd0) bump_err(k, 2);
            if (sop_v[k]) begin
                if (m_inpkt[k]) bump_err(k, 1);
                m_last[k] = data_v[k][255:224];
                m_chan[k] = ch_v[k];
                m_len[k]  = 1;
                m_by[k]   = sat(m_by[k] + add, CMAX);
                if (eop_v[k]) end_packet(k);
                else m_inpkt[k] = 1'b1;
            end else if (!m_inpkt[k]) begin
                bump_err(k, 0);
            end else begin
                m_len[k] = sat(m_len[k] + 1, CMAX);
                if (ch_v[k] != m_chan[k]) bump_err(k, 3);
                m_by[k] = sat(m_by[k] + add, CMAX);
                if (eop_v[k]) end_packet(k);
            end
        end
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) model_update(k);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs(input int k);
        data_v[k]  = '0;
        ch_v[k]    = 2'd0;
        valid_v[k] = 1'b0;
        sop_v[k]   = 1'b0;
        eop_v[k]   = 1'b0;
        empty_v[k] = 5'd0;
        addr_v[k]  = 3'd0;
        read_v[k]  = 1'b0;
        write_v[k] = 1'b0;
        wdata_v[k] = 32'd0;
    endtask

    task automatic send_beat(input int k, input bit sop, input bit eop, input bit [4:0] emp,
                             input bit [1:0] ch, input bit [31:0] top, input bit with_clear);
        bit acc = 1'b0;
        data_v[k][255:224] = top;
        for (int i = 0; i < 7; i++) data_v[k][i*32 +: 32] = $urandom;
        sop_v[k]   = sop;
        eop_v[k]   = eop;
        empty_v[k] = emp;
        ch_v[k]    = ch;
        valid_v[k] = 1'b1;
        if (with_clear) begin
            addr_v[k]  = 3'd0;
            write_v[k] = 1'b1;
            wdata_v[k] = 32'd1;
        end
        for (int n = 0; n < 16 && !acc; n++) begin
            acc = m_ready[k];
            step();
        end
        valid_v[k] = 1'b0;
        write_v[k] = 1'b0;
        chk($sformatf("k%0d_beat_accept", k), {31'd0, acc}, 32'd1);
    endtask

    task automatic csr_clear(input int k);
        addr_v[k]  = 3'd0;
        wdata_v[k] = 32'd1;
        write_v[k] = 1'b1;
        step();
        write_v[k] = 1'b0;
    endtask

    task automatic csr_check(input int k, input logic [2:0] a, input logic [31:0] exp, input string name);
        addr_v[k] = a;
        read_v[k] = 1'b1;
        step();
        read_v[k] = 1'b0;
        chk($sformatf("k%0d_%s", k, name), (k == 0) ? rdata_0 : rdata_1, exp);
    endtask

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) begin
                chk("ready_ff", {31'd0, ready_0}, {31'd0, m_ready[0]});
                chk("ready_a5", {31'd0, ready_1}, {31'd0, m_ready[1]});
                chk("rdata_ff", rdata_0, m_rd[0]);
                chk("rdata_a5", rdata_1, m_rd[1]);
            end
        end
    end

    initial begin
        logic [7:0]  cap0, cap1;
        logic [31:0] rd;
        pat[0] = 8'hFF;
        pat[1] = 8'hA5;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_inputs(k);
            model_reset(k);
        end
        cmp_en = 1'b1;
        repeat (3) step();
        chk("reset_ready_ff", {31'd0, ready_0}, 32'd0);
        chk("reset_rdata_a5", rdata_1, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            cap0[i] = ready_0;
            cap1[i] = ready_1;
        end
        chk("ready_seq_ff", {24'd0, cap0}, 32'h0000_00FF);
        chk("ready_seq_a5", {24'd0, cap1}, 32'h0000_00A5);

        for (int k = 0; k < 2; k++) begin
            // Ten two-beat packets.
            csr_clear(k);
            for (int p = 0; p < 10; p++) begin
                send_beat(k, 1'b1, 1'b0, 5'd0, 2'd1, (p == 9) ? 32'hbcb55656 : $urandom, 1'b0);
                send_beat(k, 1'b0, 1'b1, 5'd0, 2'd1, $urandom, 1'b0);
            end
            csr_check(k, 3'd0, 32'd10, "t1_packets");
            csr_check(k, 3'd1, 32'd20, "t1_beats");
            csr_check(k, 3'd2, 32'd640, "t1_bytes");
            csr_check(k, 3'd3, 32'd0, "t1_errors");
            csr_check(k, 3'd4, 32'hbcb55656, "t1_last_sop");
            csr_check(k, 3'd5, 32'd2, "t1_max_len");

            // Single-beat packet with empty, then an orphan.
            csr_clear(k);
            send_beat(k, 1'b1, 1'b1, 5'd5, 2'd0, $urandom, 1'b0);
            csr_check(k, 3'd0, 32'd1, "t3_packets");
            csr_check(k, 3'd2, 32'd27, "t3_bytes");
            send_beat(k, 1'b0, 1'b1, 5'd0, 2'd0, $urandom, 1'b0);
            csr_check(k, 3'd3, 32'h0000_0001, "t3_orphan");
            csr_check(k, 3'd0, 32'd1, "t3_packets_after");
            csr_check(k, 3'd2, 32'd27, "t3_bytes_after");

            // Missing EOP, then a non-EOP beat carrying empty.
            csr_clear(k);
            send_beat(k, 1'b1, 1'b0, 5'd0, 2'd0, $urandom, 1'b0);
            send_beat(k, 1'b1, 1'b0, 5'd0, 2'd0, $urandom, 1'b0);
            send_beat(k, 1'b0, 1'b1, 5'd0, 2'd0, $urandom, 1'b0);
            csr_check(k, 3'd0, 32'd1, "t4_packets");
            csr_check(k, 3'd5, 32'd2, "t4_max_len");
            send_beat(k, 1'b1, 1'b0, 5'd3, 2'd0, $urandom, 1'b0);
            csr_check(k, 3'd3, 32'h0001_0100, "t4_errors");
            csr_check(k, 3'd2, 32'd128, "t4_bytes");

            // Channel change inside a packet, then clear colliding with a beat.
            csr_clear(k);
            send_beat(k, 1'b1, 1'b0, 5'd0, 2'd0, $urandom, 1'b0);
            send_beat(k, 1'b0, 1'b1, 5'd0, 2'd2, $urandom, 1'b0);
            csr_check(k, 3'd3, 32'h0100_0000, "t5_chan");
            send_beat(k, 1'b1, 1'b0, 5'd0, 2'd1, $urandom, 1'b1);
            for (int a = 0; a < 6; a++) csr_check(k, 3'(a), 32'd0, "t5_cleared");
            addr_v[k] = 3'd6;
            read_v[k] = 1'b1;
            step();
            read_v[k] = 1'b0;
            rd = (k == 0) ? rdata_0 : rdata_1;
            chk($sformatf("k%0d_t5_status_idle", k), rd & 32'hFFFF_FFFE, 32'd0);

            // Asynchronous reset in the middle of a packet.
            send_beat(k, 1'b1, 1'b0, 5'd0, 2'd0, $urandom, 1'b0);
            repeat ($urandom_range(0, 4)) step();
            #($urandom_range(1, 6));
            reset_n = 1'b0;
            model_reset(0);
            model_reset(1);
            #1;
            chk("async_ready_ff", {31'd0, ready_0}, 32'd0);
            chk("async_ready_a5", {31'd0, ready_1}, 32'd0);
            repeat (2) step();
            reset_n = 1'b1;
            for (int a = 0; a < 6; a++) csr_check(k, 3'(a), 32'd0, "t6_after_reset");
            send_beat(k, 1'b0, 1'b1, 5'd0, 2'd0, $urandom, 1'b0);
            csr_check(k, 3'd3, 32'h0000_0001, "t6_orphan");
            csr_check(k, 3'd7, 32'hFC0DC4EC, "t6_id");
        end

        // Random traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                valid_v[k] = ($urandom_range(0, 9) < 7);
                sop_v[k]   = ($urandom_range(0, 9) < 3);
                eop_v[k]   = ($urandom_range(0, 9) < 3);
                empty_v[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
                if ($urandom_range(0, 9) < 2) ch_v[k] = 2'($urandom);
                for (int i = 0; i < 8; i++) data_v[k][i*32 +: 32] = $urandom;
                read_v[k]  = ($urandom_range(0, 9) < 5);
                addr_v[k]  = 3'($urandom);
                write_v[k] = ($urandom_range(0, 99) < 3);
                wdata_v[k] = $urandom;
            end
            step();
        end
        for (int k = 0; k < 2; k++) idle_inputs(k);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_debug_checker.md
Name: fc_debug_checker

Overview:
- Avalon-ST sink that consumes the 256-bit debug packet stream from the FC debug generator.
- Checks SOP/EOP framing and the empty field, and counts packets, beats, bytes and errors.
- Applies a programmable backpressure pattern to ready so the generator's ready handling gets exercised.
- Exposes its statistics through a small Avalon-MM CSR slave, which is read by the debug CPU.

Parameters:
- DATA_W, 256, stream data width in bits; must equal 8*2**EMPTY_W.
- EMPTY_W, 5, width of the empty field.
- CNT_W, 32, width of every statistics counter.
- READY_PATTERN, 8'hFF, 8-bit rotating mask that drives st_in_ready; bit i applies on cycle i mod 8.

Ports:
- clk  in  1  single clock for stream and CSR.
- reset_n  in  1  asynchronous active-low reset.
- st_in_data  in  DATA_W  stream data.
- st_in_channel  in  2  stream channel.
- st_in_valid  in  1  beat valid.
- st_in_ready  out  1  beat accept.
- st_in_startofpacket  in  1  SOP.
- st_in_endofpacket  in  1  EOP.
- st_in_empty  in  EMPTY_W  unused bytes on EOP beat.
- avs_address  in  3  CSR word address.
- avs_read  in  1  CSR read strobe.
- avs_readdata  out  32  CSR read data.
- avs_write  in  1  CSR write strobe.
- avs_writedata  in  32  CSR write data.

Behaviour:
- Reset: asynchronous assert, synchronous deassert. While reset_n=0:
  - all counters, FSM and pattern index are cleared;
  - st_in_ready=0;
  - avs_readdata=0;
  - pattern index=0.
- Ready:
  - st_in_ready is registered and equals READY_PATTERN[idx].
  - idx advances by 1 every cycle after reset, wrapping from 7 to 0.
  - The first cycle after reset shows bit 0.
  - A beat is accepted when st_in_valid and st_in_ready are both 1. Nothing else is sampled.
- Framing FSM, states IDLE and IN_PKT, evaluated on accepted beats only:
  - IDLE, SOP=1, EOP=1: single-beat packet. packets+1, stay IDLE.
  - IDLE, SOP=1, EOP=0: go to IN_PKT.
  - IDLE, SOP=0: orphan beat. err_orphan+1, stay IDLE, beat not counted in bytes.
  - IN_PKT, SOP=0, EOP=1: packets+1, go to IDLE.
  - IN_PKT, SOP=1: missing EOP. err_sop+1; the new SOP starts a new packet. Go to IDLE if EOP=1, else stay IN_PKT.
  - IN_PKT, SOP=0, EOP=0: stay IN_PKT.
- Empty check: an accepted non-EOP beat with empty!=0 increments err_empty; the empty value is otherwise ignored for that beat.
- Channel check: a beat inside a packet whose channel differs from the SOP channel increments err_chan.
- Counting:
  - beats increments on every accepted beat, including errored ones.
  - bytes adds 32 for each counted non-EOP beat, and 32-empty for an EOP beat. Addition is CNT_W wide.
  - Every counter saturates at all-ones; there is no wrap-around.
- Captures:
  - last_sop_word holds st_in_data[DATA_W-1 -: 32] of the most recent accepted SOP beat.
  - max_len holds the maximum packet length in beats, updated on EOP.
- CSR map. Reads have 1-cycle latency: avs_readdata is valid the cycle after avs_read and holds otherwise.
  - 0: packets
  - 1: beats
  - 2: bytes
  - 3: {err_chan[7:0], err_empty[7:0], err_sop[7:0], err_orphan[7:0]}. Error counters are 8-bit and saturating.
  - 4: last_sop_word
  - 5: max_len
  - 6: {30'b0, state==IN_PKT, st_in_ready}
  - 7: 32'hFC0DC4EC, a constant ID.
- Clear: a write to address 0 with writedata[0]=1 clears every counter, max_len and last_sop_word, and forces the FSM to IDLE. The FSM and idx are untouched otherwise.
  - If a beat is accepted in the same cycle as a clear, the clear wins and the beat is dropped from statistics.
  - Writes to any other address are ignored.
- Simultaneous read and clear: the read returns the pre-clear value.
- Reset asserted mid-packet: the FSM returns to IDLE. A following non-SOP beat counts as orphan.

Decomposition:
- Package fc_debug_pkg holds:
  - the CSR address constants;
  - the ID constant;
  - a typedef enum logic {IDLE, IN_PKT} chk_state_t;
  - a typedef for the packed error word.
- One sub-module, fc_debug_sat_counter: parameterised width and increment, saturating, with synchronous clear and asynchronous reset_n. It is instantiated once per counter.

Test Plan:
- Two-beat packets (SOP, then EOP with empty=0), 10 packets, READY_PATTERN=8'hFF. Expect: packets=10, beats=20, bytes=640, all errors 0, last_sop_word=32'hbcb55656, max_len=2.
- Same stream with READY_PATTERN=8'hA5. Expect: ready follows 1,0,1,0,0,1,0,1 from reset, the accepted-beat count matches the handshakes, and the counters are identical to the first test.
- Single beat with SOP=1, EOP=1, empty=5. Expect: packets=1, bytes=27. Then a beat with SOP=0, EOP=1. Expect: err_orphan=1, packets unchanged.
- SOP beat, then a second SOP beat before any EOP, then EOP. Expect: err_sop=1, packets=1, max_len=2. Also a non-EOP beat with empty=3. Expect: err_empty=1.
- Channel 0 SOP followed by a channel 2 EOP. Expect: err_chan=1. Then write 1 to address 0 in the same cycle as an accepted beat. Expect: every counter reads 0 afterwards and a read of address 6 shows IDLE.
- Assert reset_n=0 mid-packet and on a random cycle. Expect: ready=0 immediately (asynchronously), all CSRs 0 after release, and the next EOP-only beat counted as orphan. Read address 7. Expect: 32'hFC0DC4EC.
